// File: rtl/im_loader_if.sv
// Byte-stream input and IM write port of the image loader, bundled together.
// slave = loader side, master = byte source / IM side.
interface im_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory image loader: packs a big-endian byte stream into 32-bit
// words, writes them to IM from BASE_ADDR upward, and keeps the CPU held until
// the final byte of the image has been written.
module im_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    im_loader_if.slave       bus,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {LOAD, WRITE, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic               last_q, last_d;
    logic [31:0]        next_addr_q, next_addr_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic [31:0]        im_addr_q, im_addr_d;
    logic [31:0]        im_wdata_q, im_wdata_d;

    // Next-state: byte assembly in LOAD, single write cycle, terminal DONE/ERR.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        last_d       = last_q;
        next_addr_d  = next_addr_q;
        word_count_d = word_count_q;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;

        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    // A byte arriving with IM already full is an overflow; nothing is written.
                    if (word_count_q == CNT_W'(DEPTH_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        // Byte k lands in bits [31-8k:24-8k]; unfilled bytes stay zero.
                        word_d = word_q | ({bus.in_data, 24'h0} >> {byte_idx_q, 3'b000});
                        if (byte_idx_q == 2'd3 || bus.in_last) begin
                            last_d     = bus.in_last;
                            im_addr_d  = next_addr_q;
                            im_wdata_d = word_d;
                            state_d    = WRITE;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
            end
            WRITE: begin
                next_addr_d  = next_addr_q + 32'd4;
                word_count_d = word_count_q + CNT_W'(1);
                byte_idx_d   = 2'd0;
                word_d       = 32'h0;
                state_d      = last_q ? DONE : LOAD;
            end
            DONE:    state_d = DONE;
            default: state_d = ERR;
        endcase
    end

    // State registers; reset discards any partial word but leaves IM untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'h0;
            last_q       <= 1'b0;
            next_addr_q  <= BASE_ADDR;
            word_count_q <= '0;
            im_addr_q    <= BASE_ADDR;
            im_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            last_q       <= last_d;
            next_addr_q  <= next_addr_d;
            word_count_q <= word_count_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
        end
    end

    // Outputs decoded from state; address/data hold last written values.
    always_comb begin
        bus.in_ready = (state_q == LOAD);
        bus.im_we    = (state_q == WRITE);
        bus.im_addr  = im_addr_q;
        bus.im_wdata = im_wdata_q;
        cpu_hold     = (state_q != DONE);
        load_done    = (state_q == DONE);
        load_err     = (state_q == ERR);
        word_count   = word_count_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: scoreboard of expected IM writes,
// default-size instance (a) and a 2-word instance (b) for overflow.
module tb_im_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    im_loader_if a_if ();
    im_loader_if b_if ();

    logic        a_hold, a_done, a_err;
    logic [10:0] a_wc;
    logic        b_hold, b_done, b_err;
    logic [1:0]  b_wc;

    im_loader dut_a (
        .clk(clk), .reset(reset), .bus(a_if),
        .cpu_hold(a_hold), .load_done(a_done), .load_err(a_err), .word_count(a_wc)
    );

    im_loader #(.BASE_ADDR(32'h0000_3000), .DEPTH_WORDS(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if),
        .cpu_hold(b_hold), .load_done(b_done), .load_err(b_err), .word_count(b_wc)
    );

    int total = 0;
    int bad   = 0;
    int we_a  = 0;
    int we_b  = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every im_we pulse must match the head of its scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (a_if.im_we === 1'b1) begin
            we_a++;
            if (qa.size() == 0) chk("a_unexp_we", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_addr", a_if.im_addr, e[63:32]);
                chk("a_data", a_if.im_wdata, e[31:0]);
            end
        end
        if (b_if.im_we === 1'b1) begin
            we_b++;
            if (qb.size() == 0) chk("b_unexp_we", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_addr", b_if.im_addr, e[63:32]);
                chk("b_data", b_if.im_wdata, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns one negedge after the byte is consumed, valid still high.
    task automatic send(input bit sel_b, input logic [7:0] d, input bit last);
        int n = 0;
        if (sel_b) begin
            b_if.in_valid = 1'b1; b_if.in_data = d; b_if.in_last = last;
            while (b_if.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end else begin
            a_if.in_valid = 1'b1; a_if.in_data = d; a_if.in_last = last;
            while (a_if.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        idle(0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes3 [6];
        a_if.in_valid = 1'b0; a_if.in_data = 8'h0; a_if.in_last = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = 8'h0; b_if.in_last = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_hold", 32'(a_hold), 32'd1);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_wc", 32'(a_wc), 32'd0);
        chk("rst_addr", a_if.im_addr, 32'h3000);
        chk("rst_wdata", a_if.im_wdata, 32'h0);
        chk("rst_we", 32'(a_if.im_we), 32'd0);
        chk("rst_ready", 32'(a_if.in_ready), 32'd1);

        // 1: single word with last on 4th byte
        qa.push_back({32'h3000, 32'h3C081234});
        send(0, 8'h3C, 0); send(0, 8'h08, 0); send(0, 8'h12, 0); send(0, 8'h34, 1);
        idle(0);
        chk("t1_we_now", 32'(a_if.im_we), 32'd1);
        chk("t1_done_early", 32'(a_done), 32'd0);
        @(negedge clk);
        chk("t1_done", 32'(a_done), 32'd1);
        chk("t1_hold", 32'(a_hold), 32'd0);
        chk("t1_wc", 32'(a_wc), 32'd1);
        chk("t1_ready", 32'(a_if.in_ready), 32'd0);
        chk("t1_we_cnt", 32'(we_a), 32'd1);
        chk("t1_sb", 32'(qa.size()), 32'd0);

        // 2: eight bytes back to back, no last
        do_reset();
        we_a = 0;
        qa.push_back({32'h3000, 32'h00010203});
        qa.push_back({32'h3004, 32'h04050607});
        for (int i = 0; i < 8; i++) begin
            send(0, 8'(i), 0);
            if (i % 4 == 3) begin
                chk("t2_ready_w", 32'(a_if.in_ready), 32'd0);
                chk("t2_we", 32'(a_if.im_we), 32'd1);
            end else begin
                chk("t2_ready_l", 32'(a_if.in_ready), 32'd1);
            end
        end
        idle(2);
        chk("t2_wc", 32'(a_wc), 32'd2);
        chk("t2_done", 32'(a_done), 32'd0);
        chk("t2_hold", 32'(a_hold), 32'd1);
        chk("t2_ready", 32'(a_if.in_ready), 32'd1);
        chk("t2_we_cnt", 32'(we_a), 32'd2);
        chk("t2_sb", 32'(qa.size()), 32'd0);

        // 3: partial last word padded, with random gaps between bytes
        do_reset();
        we_a = 0;
        bytes3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        qa.push_back({32'h3000, 32'h11223344});
        qa.push_back({32'h3004, 32'hAABB0000});
        for (int i = 0; i < 6; i++) begin
            send(0, bytes3[i], i == 5);
            idle($urandom_range(0, 3));
        end
        idle(2);
        chk("t3_done", 32'(a_done), 32'd1);
        chk("t3_hold", 32'(a_hold), 32'd0);
        chk("t3_wc", 32'(a_wc), 32'd2);
        chk("t3_sb", 32'(qa.size()), 32'd0);

        // 6: in DONE, valid bytes are ignored
        a_if.in_valid = 1'b1; a_if.in_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_ready", 32'(a_if.in_ready), 32'd0);
            chk("t6_we", 32'(a_if.im_we), 32'd0);
        end
        idle(1);
        chk("t6_wc", 32'(a_wc), 32'd2);
        chk("t6_done", 32'(a_done), 32'd1);
        chk("t6_we_cnt", 32'(we_a), 32'd2);

        // 5: partial word discarded by reset
        do_reset();
        we_a = 0;
        send(0, 8'h01, 0); send(0, 8'h02, 0);
        do_reset();
        qa.push_back({32'h3000, 32'hDEADBEEF});
        send(0, 8'hDE, 0); send(0, 8'hAD, 0); send(0, 8'hBE, 0); send(0, 8'hEF, 1);
        idle(2);
        chk("t5_done", 32'(a_done), 32'd1);
        chk("t5_wc", 32'(a_wc), 32'd1);
        chk("t5_we_cnt", 32'(we_a), 32'd1);
        chk("t5_sb", 32'(qa.size()), 32'd0);

        // 4: overflow on the 2-word instance
        do_reset();
        we_b = 0;
        qb.push_back({32'h3000, 32'h00112233});
        qb.push_back({32'h3004, 32'h44556677});
        for (int i = 0; i < 8; i++) send(1, 8'(i * 8'h11), 0);
        idle(2);
        chk("t4_wc", 32'(b_wc), 32'd2);
        chk("t4_err_pre", 32'(b_err), 32'd0);
        send(1, 8'h88, 0);
        chk("t4_err", 32'(b_err), 32'd1);
        chk("t4_hold", 32'(b_hold), 32'd1);
        chk("t4_ready", 32'(b_if.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_ready_hold", 32'(b_if.in_ready), 32'd0);
        end
        idle(2);
        chk("t4_err_sticky", 32'(b_err), 32'd1);
        chk("t4_done", 32'(b_done), 32'd0);
        chk("t4_we_cnt", 32'(we_b), 32'd2);
        chk("t4_sb", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
